slot_phase_timer: RTL and testbench

SLOT_PHASE_TIMER -- requirements
Module: slot_phase_timer

---
 rtl/slot_phase_timer_pkg.sv | 20 ++
 rtl/slot_phase_timer_sat_cnt.sv | 34 +++
 rtl/slot_phase_timer.sv | 138 +++++++++++++
 tb/tb_slot_phase_timer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_phase_timer_pkg.sv
// Shared definitions for the slot phase timer: slot state encoding and
// width helpers for phase indices and counter compare paths.
package slv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_TIMEOUT = 2'd2
    } slot_state_e;

    function automatic int unsigned phase_idx_w(input int unsigned num_phases);
        return (num_phases > 1) ? $clog2(num_phases) : 1;
    endfunction

    // One extra bit so "count + 1" can be compared without wrapping.
    function automatic int unsigned cnt_cmp_w(input int unsigned cnt_width);
        return cnt_width + 1;
    endfunction

endpackage

// File: rtl/slot_phase_timer_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment, and the count holds at all-ones instead of wrapping.
module sat_cnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/slot_phase_timer.sv
// Per-slot transaction phase timer with per-phase cycle budgets and a sticky
// timeout flag. Optional stall counter enabled by SLOT_TIMER_STALL_CNT_EN.
module slot_phase_timer
    import slv_pkg::*;
#(
    parameter int unsigned  CntWidth  = 8,
    parameter int unsigned  NumPhases = 4,
    parameter type          id_t      = logic,
    localparam int unsigned PhW       = phase_idx_w(NumPhases)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               alloc_i,
    input  id_t                                id_i,
    input  logic                               phase_adv_i,
    input  logic                               stall_i,
    input  logic                               retire_i,
    input  logic [NumPhases-1:0][CntWidth-1:0] budget_i,
    output logic                               busy_o,
    output id_t                                id_o,
    output logic [PhW-1:0]                     phase_o,
    output logic [CntWidth-1:0]                cnt_o,
    output logic [CntWidth-1:0]                stall_cnt_o,
    output logic                               timeout_o,
    output logic [PhW-1:0]                     timeout_phase_o,
    output logic                               alloc_err_o
);

    localparam int unsigned    CmpW      = cnt_cmp_w(CntWidth);
    localparam logic [PhW-1:0] LastPhase = PhW'(NumPhases - 1);

    slot_state_e         state_q, state_d;
    logic [PhW-1:0]      phase_q, phase_d;
    logic [PhW-1:0]      to_phase_q, to_phase_d;
    id_t                 id_q, id_d;
    logic                alloc_err_q, alloc_err_d;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] budget_sel;
    logic                busy, active, adv_ok, cnt_clr, cnt_inc, budget_hit;

    assign busy    = (state_q != ST_IDLE);
    assign active  = (state_q == ST_ACTIVE);
    // Retire outranks everything; an advance out of the last phase is a no-op.
    assign adv_ok  = active && !retire_i && phase_adv_i && (phase_q != LastPhase);
    assign cnt_inc = active && !retire_i && !adv_ok;
    assign cnt_clr = !busy || retire_i || adv_ok;

    assign budget_sel = budget_i[phase_q];
    assign budget_hit = cnt_inc && (budget_sel != '0) &&
                        (({1'b0, cnt_q} + CmpW'(1)) == {1'b0, budget_sel});

    sat_cnt #(.Width(CntWidth)) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt_q)
    );

`ifdef SLOT_TIMER_STALL_CNT_EN
    sat_cnt #(.Width(CntWidth)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc && stall_i),
        .cnt_o  (stall_cnt_o)
    );
`else
    logic unused_stall;
    assign unused_stall = stall_i;
    assign stall_cnt_o  = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            to_phase_q  <= '0;
            id_q        <= '0;
            alloc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            to_phase_q  <= to_phase_d;
            id_q        <= id_d;
            alloc_err_q <= alloc_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (alloc_i) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (retire_i)        state_d = ST_IDLE;
                else if (budget_hit) state_d = ST_TIMEOUT;
            end
            ST_TIMEOUT: begin
                if (retire_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        phase_d     = phase_q;
        to_phase_d  = to_phase_q;
        id_d        = id_q;
        alloc_err_d = busy && alloc_i;
        if (!busy) begin
            if (alloc_i) begin
                phase_d    = '0;
                to_phase_d = '0;
                id_d       = id_i;
            end
        end else if (retire_i) begin
            phase_d    = '0;
            to_phase_d = '0;
        end else if (adv_ok) begin
            phase_d = phase_q + PhW'(1);
        end else if (budget_hit) begin
            to_phase_d = phase_q;
        end
    end

    always_comb begin
        busy_o          = busy;
        id_o            = id_q;
        phase_o         = phase_q;
        cnt_o           = cnt_q;
        timeout_o       = (state_q == ST_TIMEOUT);
        timeout_phase_o = to_phase_q;
        alloc_err_o     = alloc_err_q;
    end

endmodule

// File: tb/tb_slot_phase_timer.sv
// Scoreboard bench for slot_phase_timer: driver feeds a behavioural model and
// queues expected outputs; a negedge monitor compares them against the DUT.
module tb_slot_phase_timer;

    localparam int CW   = 8;
    localparam int NP   = 4;
    localparam int CMAX = 255;
`ifdef SLOT_TIMER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef logic [3:0] tid_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic alloc = 1'b0, adv = 1'b0, stall = 1'b0, retire = 1'b0;
    tid_t id_in = '0;
    logic [NP-1:0][CW-1:0] budget = '0;
    logic [NP-1:0][CW-1:0] bud_pend = '0;

    logic          busy_o, timeout_o, alloc_err_o;
    tid_t          id_o;
    logic [1:0]    phase_o, timeout_phase_o;
    logic [CW-1:0] cnt_o, stall_cnt_o;

    slot_phase_timer #(.CntWidth(CW), .NumPhases(NP), .id_t(tid_t)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .alloc_i         (alloc),
        .id_i            (id_in),
        .phase_adv_i     (adv),
        .stall_i         (stall),
        .retire_i        (retire),
        .budget_i        (budget),
        .busy_o          (busy_o),
        .id_o            (id_o),
        .phase_o         (phase_o),
        .cnt_o           (cnt_o),
        .stall_cnt_o     (stall_cnt_o),
        .timeout_o       (timeout_o),
        .timeout_phase_o (timeout_phase_o),
        .alloc_err_o     (alloc_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic       busy;
        tid_t       id;
        logic [1:0] ph;
        logic [7:0] cnt;
        logic [7:0] st;
        logic       to;
        logic [1:0] tph;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: slot contents as plain integers.
    bit   m_busy, m_to, m_err;
    int   m_ph, m_cnt, m_st, m_tph;
    tid_t m_id;

    task automatic model_reset();
        m_busy = 0; m_to = 0; m_err = 0;
        m_ph = 0; m_cnt = 0; m_st = 0; m_tph = 0; m_id = '0;
    endtask

    task automatic model_step(input bit a, input tid_t idv, input bit ad, input bit st, input bit ret);
        m_err = m_busy && a;
        if (!m_busy) begin
            if (a) begin
                m_busy = 1; m_to = 0; m_ph = 0; m_cnt = 0; m_st = 0; m_tph = 0; m_id = idv;
            end
        end else if (ret) begin
            m_busy = 0; m_to = 0; m_ph = 0; m_cnt = 0; m_st = 0; m_tph = 0;
        end else if (!m_to) begin
            if (ad && m_ph < NP - 1) begin
                m_ph = m_ph + 1; m_cnt = 0; m_st = 0;
            end else begin
                if (int'(budget[m_ph]) != 0 && m_cnt + 1 == int'(budget[m_ph])) begin
                    m_to = 1; m_tph = m_ph;
                end
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                if (st && STALL_EN) m_st = (m_st < CMAX) ? m_st + 1 : CMAX;
            end
        end
    endtask

    task automatic drive(input bit a, input tid_t idv, input bit ad, input bit st, input bit ret);
        exp_t e;
        budget = bud_pend;
        alloc = a; id_in = idv; adv = ad; stall = st; retire = ret;
        model_step(a, idv, ad, st, ret);
        e.due  = cyc + 1;
        e.busy = m_busy;
        e.id   = m_id;
        e.ph   = m_ph[1:0];
        e.cnt  = m_cnt[7:0];
        e.st   = m_st[7:0];
        e.to   = m_to;
        e.tph  = m_tph[1:0];
        e.err  = m_err;
        q.push_back(e);
    endtask

    task automatic step(input bit a, input tid_t idv, input bit ad, input bit st, input bit ret);
        @(posedge clk); #1;
        drive(a, idv, ad, st, ret);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, '0, 0, 0, 0);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_chk++;
        if ({busy_o, id_o, phase_o, cnt_o, stall_cnt_o, timeout_o, timeout_phase_o, alloc_err_o} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs not zero busy=%b id=%h ph=%0d cnt=%0d st=%0d to=%b tph=%0d err=%b",
                     name, busy_o, id_o, phase_o, cnt_o, stall_cnt_o, timeout_o, timeout_phase_o, alloc_err_o);
        end
    endtask

    // Asserts reset mid-cycle, checks outputs clear with no clock edge, releases mid-cycle.
    task automatic async_reset(input string name);
        @(posedge clk); #3;
        rst_ni = 1'b0;
        q.delete();
        alloc = 0; adv = 0; stall = 0; retire = 0;
        model_reset();
        #1;
        check_all_zero(name);
        @(posedge clk);
        @(posedge clk); #3;
        rst_ni = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_ni) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_chk++;
                if ({busy_o, id_o, phase_o, cnt_o, stall_cnt_o, timeout_o, timeout_phase_o, alloc_err_o} !==
                    {e.busy, e.id, e.ph, e.cnt, e.st, e.to, e.tph, e.err}) begin
                    n_fail++;
                    $display("FAIL cycle %0d outputs: got busy=%b id=%h ph=%0d cnt=%0d st=%0d to=%b tph=%0d err=%b; expected busy=%b id=%h ph=%0d cnt=%0d st=%0d to=%b tph=%0d err=%b",
                             cyc, busy_o, id_o, phase_o, cnt_o, stall_cnt_o, timeout_o, timeout_phase_o, alloc_err_o,
                             e.busy, e.id, e.ph, e.cnt, e.st, e.to, e.tph, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pat[8];
        model_reset();
        #2;
        check_all_zero("reset_state");

        // Budget {0,10,0,0}: alloc on the first edge after reset release.
        bud_pend = '0;
        bud_pend[1] = 8'd10;
        @(posedge clk);
        @(posedge clk); #3;
        rst_ni = 1'b1;
        drive(1, 4'h5, 0, 0, 0);
        idle(3);
        step(0, '0, 1, 0, 0);
        n = 0;
        while (n < 20) begin
            step(0, '0, 0, 0, 0);
            n++;
            if (timeout_o) break;
        end
        check_val("timeout_latency", n, 11);
        check_val("timeout_phase", int'(timeout_phase_o), 1);
        idle(3);
        step(0, '0, 1, 1, 0);
        step(1, 4'h2, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        idle(2);

        // All budgets zero: counter saturates, no timeout.
        bud_pend = '0;
        step(1, 4'h9, 0, 0, 0);
        idle(300);
        check_val("cnt_saturated", int'(cnt_o), 255);
        check_val("no_timeout_sat", int'(timeout_o), 0);
        step(0, '0, 0, 0, 1);
        idle(1);

        // Stall accounting in phase 2.
        pat = '{1, 0, 1, 1, 0, 1, 0, 1};
        step(1, 4'hC, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        foreach (pat[i]) step(0, '0, 0, pat[i] != 0, 0);
        step(0, '0, 1, 0, 0);
        check_val("phase2_cnt", int'(cnt_o), 8);
        check_val("phase2_stall", int'(stall_cnt_o), STALL_EN ? 5 : 0);
        idle(2);
        step(0, '0, 1, 1, 0);
        step(0, '0, 1, 1, 0);
        step(0, '0, 0, 1, 1);
        idle(1);

        // Retire together with advance, then on the budget-hit cycle.
        step(1, 4'h3, 0, 0, 0);
        idle(2);
        step(0, '0, 1, 0, 1);
        idle(2);
        bud_pend[0] = 8'd4;
        step(1, 4'h4, 0, 0, 0);
        idle(3);
        step(0, '0, 1, 0, 1);
        idle(3);

        // Alloc while busy.
        step(1, 4'h1, 0, 0, 0);
        idle(2);
        step(1, 4'hA, 0, 0, 0);
        idle(1);
        step(1, 4'hB, 0, 0, 1);
        idle(2);

        // Reset while in TIMEOUT, then fresh alloc right after release.
        bud_pend[0] = 8'd3;
        step(1, 4'h6, 0, 0, 0);
        idle(6);
        async_reset("reset_in_timeout");
        drive(1, 4'h7, 0, 0, 0);
        idle(3);
        step(0, '0, 0, 0, 1);
        idle(1);

        // Random traffic with occasionally changing budgets.
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                for (int p = 0; p < NP; p++)
                    bud_pend[p] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
            end
            step($urandom_range(0, 9) == 0, 4'($urandom), $urandom_range(0, 6) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end
        idle(2);

        @(posedge clk);
        @(posedge clk); #1;
        check_val("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
